// File: rtl/priority_encoder_8.sv
// ============================================================================
// Module      : priority_encoder_8
// Description : Sequential 8-to-3 encoder. Captures a request vector and
//               streams the index of every set bit, one per handshake.
//               Build option PRIORITY_ENCODER_MSB_FIRST_EN selects
//               highest-index-first ordering (default is lowest first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] In,
    input  logic       load,
    input  logic       enable,
    input  logic       ready,
    output logic [2:0] Out,
    output logic       valid,
    output logic       last,
    output logic       IDLE,
    output logic       zero
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pending;
    logic [7:0] pending_nxt;
    logic       zero_nxt;
    logic [2:0] sel_idx;
    logic       one_left;
    logic       emit_valid;

    // Selection order is the only thing the build option changes.
    always_comb begin
        sel_idx = 3'd0;
`ifdef PRIORITY_ENCODER_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) sel_idx = i[2:0];
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) sel_idx = i[2:0];
        end
`endif
    end

    assign one_left   = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);
    assign emit_valid = (state == S_EMIT) && enable;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        zero_nxt    = zero;
        if (enable) begin
            zero_nxt = 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        if (In != 8'd0) begin
                            pending_nxt = In;
                            state_nxt   = S_EMIT;
                        end else begin
                            zero_nxt = 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    // load is deliberately ignored while draining
                    if (ready) begin
                        pending_nxt          = pending;
                        pending_nxt[sel_idx] = 1'b0;
                        if (one_left) state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pending <= 8'd0;
            zero    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            zero    <= zero_nxt;
        end
    end

    assign valid = emit_valid;
    assign Out   = emit_valid ? sel_idx : 3'd0;
    assign last  = emit_valid && one_left;
    assign IDLE  = (state == S_IDLE);

endmodule

`default_nettype wire
